// File: rtl/fifo_wr_arb_if.sv
// Requester/FIFO-side bundle for the write-port arbiter. The master modport
// belongs to whoever drives the request streams and the FIFO full flag; the
// slave modport belongs to the arbiter.
interface fifo_wr_arb_if #(
  parameter int DSIZE = 8,
  parameter int NREQ  = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_last;
  logic [NREQ-1:0]       req_ready;
  logic                  wfull;
  logic                  winc;
  logic [DSIZE-1:0]      wdata;
  logic [IDW-1:0]        gnt_id;
  logic                  busy;

  modport master (
    output req_valid, req_data, req_last, wfull,
    input  req_ready, winc, wdata, gnt_id, busy
  );

  modport slave (
    input  req_valid, req_data, req_last, wfull,
    output req_ready, winc, wdata, gnt_id, busy
  );
endinterface

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing one async-FIFO write port among NREQ
// valid/ready/last requesters, entirely in the wclk domain. At most one FIFO
// write per cycle, never while wfull is high.
// Optional feature: define FIFO_ARB_PKT_LOCK_EN to hold the grant for a whole
// packet (re-arbitrate only on a transferred last beat). Without it every
// transferred beat is a re-arbitration point and req_last is ignored.
module fifo_wr_arb #(
  parameter int DSIZE = 8,
  parameter int NREQ  = 4
) (
  input logic          wclk,
  input logic          wrst,
  fifo_wr_arb_if.slave bus
);
  localparam int IDW = $clog2(NREQ);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] gnt_id, gnt_nxt;
  logic [IDW-1:0] rr_ptr, rr_nxt;

  logic           busy, winc;
  logic [NREQ-1:0]  req_ready;
  logic [DSIZE-1:0] wdata;

  logic [IDW:0]    idle_pick, rearb_pick;
  logic [NREQ-1:0] holder_mask;
  logic            rearb;

  // Round-robin pick: first valid index after ptr, wrapping modulo NREQ.
  // Result is {found, index}.
  function automatic logic [IDW:0] pick(input logic [NREQ-1:0] v,
                                        input logic [IDW-1:0]  ptr);
    logic           found;
    logic [IDW-1:0] idx;
    logic [IDW-1:0] cidx;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cidx = IDW'((int'(ptr) + k) % NREQ);
      if (!found && v[cidx]) begin
        found = 1'b1;
        idx   = cidx;
      end
    end
    return {found, idx};
  endfunction

  assign holder_mask = NREQ'(1) << gnt_id;
  assign idle_pick   = pick(bus.req_valid, rr_ptr);
  // The holder's current beat is excluded, and the search starts after the
  // holder, so the holder ends up with the lowest priority.
  assign rearb_pick  = pick(bus.req_valid & ~holder_mask, gnt_id);

`ifdef FIFO_ARB_PKT_LOCK_EN
  assign rearb = winc & bus.req_last[gnt_id];
`else
  // req_last plays no part when beats may interleave.
  logic unused_last;
  assign unused_last = ^bus.req_last;
  assign rearb       = winc;
`endif

  // State, grant and round-robin pointer registers.
  always_ff @(posedge wclk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (wrst) begin
      state  <= IDLE;
      gnt_id <= '0;
      rr_ptr <= IDW'(NREQ - 1);
    end else begin
      state  <= state_nxt;
      gnt_id <= gnt_nxt;
      rr_ptr <= rr_nxt;
    end
  end

  // Next-state and grant selection.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would infer a latch.
    state_nxt = state;
    gnt_nxt   = gnt_id;
    rr_nxt    = rr_ptr;
    case (state)
      IDLE: begin
        if (idle_pick[IDW]) begin
          state_nxt = GRANT;
          gnt_nxt   = idle_pick[IDW-1:0];
        end
      end
      GRANT: begin
        if (rearb) begin
          rr_nxt = gnt_id;
          if (rearb_pick[IDW]) gnt_nxt   = rearb_pick[IDW-1:0];
          else                 state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath outputs, all gated by the GRANT state and by wfull.
  always_comb begin
    busy      = (state == GRANT);
    req_ready = '0;
    winc      = 1'b0;
    wdata     = '0;
    if (state == GRANT) begin
      req_ready[gnt_id] = ~bus.wfull;
      winc              = bus.req_valid[gnt_id] & ~bus.wfull;
      wdata             = bus.req_data[gnt_id*DSIZE +: DSIZE];
    end
  end

  assign bus.busy      = busy;
  assign bus.winc      = winc;
  assign bus.wdata     = wdata;
  assign bus.req_ready = req_ready;
  assign bus.gnt_id    = gnt_id;
endmodule

// File: tb/tb_fifo_wr_arb.sv
// Scoreboard bench for fifo_wr_arb: a 4-requester instance driven by a queue
// of pending beats, and a 3-requester instance for the modulo wrap case.
// Expected FIFO writes (requester id, data) are queued as stimulus is loaded
// and popped as winc is observed. Inputs change 1 ns after the rising edge;
// outputs are sampled on the falling edge.
module tb_fifo_wr_arb;
  localparam int DSIZE = 8;
  localparam int NREQ  = 4;

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic wclk = 1'b0;
  logic wrst;
  always #5 wclk = ~wclk;

  fifo_wr_arb_if #(.DSIZE(DSIZE), .NREQ(NREQ)) bus ();
  fifo_wr_arb_if #(.DSIZE(DSIZE), .NREQ(3))    bus3 ();

  fifo_wr_arb #(.DSIZE(DSIZE), .NREQ(NREQ)) dut (
    .wclk(wclk), .wrst(wrst), .bus(bus)
  );
  fifo_wr_arb #(.DSIZE(DSIZE), .NREQ(3)) dut3 (
    .wclk(wclk), .wrst(wrst), .bus(bus3)
  );

  beat_t pend[$];
  beat_t sb[$];
  beat_t sb3[$];
  int    wr_cyc[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;

  logic       s_busy, s_winc;
  logic [3:0] s_ready;
  logic [1:0] s_gnt;
  logic [7:0] s_wdata;

  task automatic add_beat(input int id, input logic [7:0] data, input logic last);
    beat_t b;
    b.id = 2'(id); b.data = data; b.last = last;
    pend.push_back(b);
  endtask

  task automatic expect_wr(input int id, input logic [7:0] data);
    beat_t b;
    b.id = 2'(id); b.data = data; b.last = 1'b0;
    sb.push_back(b);
  endtask

  // Present the oldest pending beat of each requester.
  task automatic drive_reqs();
    logic [3:0]  v, l;
    logic [31:0] d;
    logic        hit;
    v = '0; l = '0; d = '0;
    for (int i = 0; i < NREQ; i++) begin
      hit = 1'b0;
      for (int k = 0; k < pend.size(); k++) begin
        if (!hit && pend[k].id == 2'(i)) begin
          hit = 1'b1;
          v[i] = 1'b1;
          l[i] = pend[k].last;
          d[i*8 +: 8] = pend[k].data;
        end
      end
    end
    bus.req_valid = v;
    bus.req_last  = l;
    bus.req_data  = d;
  endtask

  // One clock: sample and score at the falling edge, retire accepted beats
  // just after the rising edge. Handshakes during reset do not count.
  task automatic cycle();
    logic [3:0] acc;
    logic       hit;
    beat_t      e;
    @(negedge wclk);
    s_busy  = bus.busy;
    s_winc  = bus.winc;
    s_ready = bus.req_ready;
    s_gnt   = bus.gnt_id;
    s_wdata = bus.wdata;
    acc     = bus.req_valid & bus.req_ready;
    if (!wrst) begin
      checks++;
      if ((|acc) !== bus.winc || (bus.winc && bus.wfull)) begin
        errors++;
        $display("FAIL handshake: winc=%b accepted=%b wfull=%b, required winc == |accepted and no write while full",
                 bus.winc, acc, bus.wfull);
      end
      if (bus.winc) begin
        wr_cyc.push_back(cyc);
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got id=%0d data=%h, required no write", bus.gnt_id, bus.wdata);
        end else begin
          e = sb.pop_front();
          if (bus.wdata !== e.data || bus.gnt_id !== e.id) begin
            errors++;
            $display("FAIL write_order: got id=%0d data=%h, required id=%0d data=%h",
                     bus.gnt_id, bus.wdata, e.id, e.data);
          end
        end
      end
    end
    @(posedge wclk);
    #1;
    cyc++;
    if (!wrst) begin
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i]) begin
          hit = 1'b0;
          for (int k = 0; k < pend.size(); k++) begin
            if (!hit && pend[k].id == 2'(i)) begin
              hit = 1'b1;
              pend.delete(k);
            end
          end
        end
      end
    end
    drive_reqs();
  endtask

  task automatic apply_reset();
    pend.delete();
    sb.delete();
    wr_cyc.delete();
    bus.wfull = 1'b0;
    drive_reqs();
    wrst = 1'b1;
    cycle();
    cycle();
    wrst = 1'b0;
  endtask

  task automatic wait_writes(input string name, input int n);
    int k = 0;
    while (wr_cyc.size() < n && k < 50) begin
      cycle();
      k++;
    end
    checks++;
    if (wr_cyc.size() < n) begin
      errors++;
      $display("FAIL %s_timeout: got %0d writes, required %0d", name, wr_cyc.size(), n);
    end
  endtask

  task automatic drain(input string name);
    int k = 0;
    while ((sb.size() != 0 || pend.size() != 0) && k < 200) begin
      cycle();
      k++;
    end
    checks++;
    if (sb.size() != 0 || pend.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d writes missing and %0d beats unaccepted, required 0 and 0",
               name, sb.size(), pend.size());
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (s_busy !== 1'b0 || s_winc !== 1'b0 || s_ready !== 4'b0 || s_gnt !== 2'd0 || s_wdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b winc=%b ready=%b gnt=%0d wdata=%h, required all 0",
               s_busy, s_winc, s_ready, s_gnt, s_wdata);
    end
    checks++;
    if (bus3.busy !== 1'b0 || bus3.gnt_id !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs3: got busy=%b gnt=%0d, required 0 and 0", bus3.busy, bus3.gnt_id);
    end
  endtask

  task automatic test_single_packet();
    apply_reset();
    add_beat(1, 8'hA1, 1'b0); add_beat(1, 8'hA2, 1'b0); add_beat(1, 8'hA3, 1'b1);
    expect_wr(1, 8'hA1); expect_wr(1, 8'hA2); expect_wr(1, 8'hA3);
    drive_reqs();
    cycle();
    checks++;
    if (s_busy !== 1'b0 || s_winc !== 1'b0) begin
      errors++;
      $display("FAIL grant_latency_idle: got busy=%b winc=%b, required 0 0", s_busy, s_winc);
    end
    cycle();
    checks++;
    if (s_busy !== 1'b1 || s_gnt !== 2'd1 || s_winc !== 1'b1) begin
      errors++;
      $display("FAIL grant_latency_grant: got busy=%b gnt=%0d winc=%b, required 1 1 1", s_busy, s_gnt, s_winc);
    end
    drain("single_packet");
    checks++;
`ifdef FIFO_ARB_PKT_LOCK_EN
    if (wr_cyc.size() != 3 || wr_cyc[2] - wr_cyc[0] != 2) begin
      errors++;
      $display("FAIL packet_spacing: got %0d writes spread over %0d cycles, required 3 over 2",
               wr_cyc.size(), wr_cyc.size() == 3 ? wr_cyc[2] - wr_cyc[0] : -1);
    end
`else
    if (wr_cyc.size() != 3 || wr_cyc[2] - wr_cyc[0] != 4) begin
      errors++;
      $display("FAIL packet_spacing: got %0d writes spread over %0d cycles, required 3 over 4",
               wr_cyc.size(), wr_cyc.size() == 3 ? wr_cyc[2] - wr_cyc[0] : -1);
    end
`endif
    cycle();
    checks++;
    if (s_busy !== 1'b0) begin
      errors++;
      $display("FAIL packet_end_idle: got busy=%b, required 0", s_busy);
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < NREQ; i++) begin
        add_beat(i, 8'(16*i + r), 1'b1);
        expect_wr(i, 8'(16*i + r));
      end
    drive_reqs();
    drain("round_robin");
    checks++;
    if (wr_cyc.size() != 12 || wr_cyc[11] - wr_cyc[0] != 11) begin
      errors++;
      $display("FAIL rr_back_to_back: got %0d writes spread over %0d cycles, required 12 over 11",
               wr_cyc.size(), wr_cyc.size() == 12 ? wr_cyc[11] - wr_cyc[0] : -1);
    end
  endtask

  task automatic test_wfull_stall();
    apply_reset();
    for (int b = 0; b < 4; b++) begin
      add_beat(0, 8'(8'h10 + b), b == 3);
      expect_wr(0, 8'(8'h10 + b));
    end
    drive_reqs();
    wait_writes("stall_first", 1);
    bus.wfull = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      checks++;
      if (s_winc !== 1'b0 || s_ready !== 4'b0) begin
        errors++;
        $display("FAIL stall_%0d: got winc=%b ready=%b, required 0 0000", k, s_winc, s_ready);
      end
    end
    bus.wfull = 1'b0;
    cycle();
    checks++;
    if (s_winc !== 1'b1 || s_wdata !== 8'h11) begin
      errors++;
      $display("FAIL stall_resume: got winc=%b wdata=%h, required 1 11", s_winc, s_wdata);
    end
    drain("wfull_stall");
  endtask

  task automatic test_interleave();
    apply_reset();
    for (int b = 0; b < 4; b++) add_beat(0, 8'(8'h40 + b), b == 3);
`ifdef FIFO_ARB_PKT_LOCK_EN
    expect_wr(0, 8'h40); expect_wr(0, 8'h41); expect_wr(0, 8'h42); expect_wr(0, 8'h43);
    expect_wr(2, 8'h50); expect_wr(2, 8'h51);
`else
    expect_wr(0, 8'h40); expect_wr(2, 8'h50); expect_wr(0, 8'h41); expect_wr(2, 8'h51);
    expect_wr(0, 8'h42); expect_wr(0, 8'h43);
`endif
    drive_reqs();
    wait_writes("interleave_first", 1);
    add_beat(2, 8'h50, 1'b0);
    add_beat(2, 8'h51, 1'b1);
    drive_reqs();
    drain("interleave");
  endtask

  task automatic test_reset_mid_packet();
    apply_reset();
    for (int b = 0; b < 4; b++) add_beat(3, 8'(8'h30 + b), b == 3);
    expect_wr(3, 8'h30); expect_wr(3, 8'h31);
    drive_reqs();
    wait_writes("midreset_first", 2);
    wrst = 1'b1;
    cycle();
    add_beat(0, 8'h05, 1'b1);
    drive_reqs();
    cycle();
    checks++;
    if (s_busy !== 1'b0 || s_winc !== 1'b0 || s_ready !== 4'b0) begin
      errors++;
      $display("FAIL midreset_outputs: got busy=%b winc=%b ready=%b, required 0 0 0000", s_busy, s_winc, s_ready);
    end
    wrst = 1'b0;
    expect_wr(0, 8'h05); expect_wr(3, 8'h32); expect_wr(3, 8'h33);
    drain("reset_mid_packet");
  endtask

  task automatic test_rr_wrap();
    logic [2:0] acc3;
    beat_t      e;
    sb3.delete();
    apply_reset();
    e.last = 1'b0;
    e.id = 2'd2; e.data = 8'h62; sb3.push_back(e);
    e.id = 2'd0; e.data = 8'h60; sb3.push_back(e);
    e.id = 2'd1; e.data = 8'h61; sb3.push_back(e);
    bus3.req_last  = 3'b111;
    bus3.req_data  = 24'h62_00_00;
    bus3.req_valid = 3'b100;
    for (int n = 0; n < 40 && sb3.size() > 0; n++) begin
      @(negedge wclk);
      acc3 = bus3.req_valid & bus3.req_ready;
      if (bus3.winc) begin
        checks++;
        if (sb3.size() == 0) begin
          errors++;
          $display("FAIL wrap_unexpected: got id=%0d data=%h, required no write", bus3.gnt_id, bus3.wdata);
        end else begin
          e = sb3.pop_front();
          if (bus3.gnt_id !== e.id || bus3.wdata !== e.data) begin
            errors++;
            $display("FAIL wrap_order: got id=%0d data=%h, required id=%0d data=%h",
                     bus3.gnt_id, bus3.wdata, e.id, e.data);
          end
        end
      end
      @(posedge wclk);
      #1;
      bus3.req_valid = bus3.req_valid & ~acc3;
      if (acc3[2]) begin
        bus3.req_data  = 24'h00_61_60;
        bus3.req_valid = 3'b011;
      end
    end
    checks++;
    if (sb3.size() != 0) begin
      errors++;
      $display("FAIL wrap_drain: got %0d writes missing, required 0", sb3.size());
    end
  endtask

  initial begin
    wrst           = 1'b1;
    bus.wfull      = 1'b0;
    bus.req_valid  = '0;
    bus.req_data   = '0;
    bus.req_last   = '0;
    bus3.wfull     = 1'b0;
    bus3.req_valid = '0;
    bus3.req_data  = '0;
    bus3.req_last  = '0;
    test_reset();
    test_single_packet();
    test_round_robin();
    test_wfull_stall();
    test_interleave();
    test_reset_mid_packet();
    test_rr_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
